// File: rtl/cadr_clk_pkg.sv
// Shared types and helpers for the CADR machine-cycle sequencer.
// FSM state encoding, delay-line tap indices and the speed-to-tap mapping.
package cadr_clk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_RISE,
    WAIT_FALL
  } state_e;

  // Delay-line tap indices (tap[0] is the 50 ns output).
  localparam logic [2:0] TAP_50  = 3'd0;
  localparam logic [2:0] TAP_100 = 3'd1;
  localparam logic [2:0] TAP_150 = 3'd2;
  localparam logic [2:0] TAP_200 = 3'd3;
  localparam logic [2:0] TAP_250 = 3'd4;

  // Terminating tap for a cycle: the long-cycle control overrides speed.
  function automatic logic [2:0] speed_to_tap(input logic [1:0] speed, input logic ilong);
    logic [2:0] t;
    if (ilong) begin
      t = TAP_250;
    end else begin
      case (speed)
        2'd0:    t = TAP_100;
        2'd1:    t = TAP_150;
        2'd2:    t = TAP_200;
        default: t = TAP_250;
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/cadr_cycle_timer_tap_edge_sync.sv
// Multi-flop synchronizer for the asynchronous delay-line taps, followed by
// a per-bit rise/fall detector producing single-clk pulses.
module tap_edge_sync #(
  parameter int W      = 5,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);

  logic [W-1:0] sync_q [STAGES];
  logic [W-1:0] prev_q;

  // Shift the raw taps through the synchronizer and keep one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/cadr_cycle_timer.sv
// CADR machine-cycle sequencer: launches a pulse into the delay line, waits
// for the selected tap to rise and fall, and emits TPCLK/TPWP/TPTSE.
// Optional feature macro: CYCLE_COUNT_EN adds the cyc_count output.
module cadr_cycle_timer
  import cadr_clk_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64
`ifdef CYCLE_COUNT_EN
  , parameter int CNT_W     = 32
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       tap,
  input  logic [1:0]       speed,
  input  logic             ilong,
  input  logic             run,
  input  logic             step_req,
  output logic             td_in,
  output logic             tpclk,
  output logic             tpwp,
  output logic             tptse,
  output logic             busy,
  output logic             fault
`ifdef CYCLE_COUNT_EN
  , output logic [CNT_W-1:0] cyc_count
`endif
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [4:0]      tap_rise, tap_fall;
  state_e          state_q;
  logic [2:0]      sel_q;
  logic [WD_W-1:0] wd_q;
  logic            td_in_q, tptse_q, tpclk_q, tpwp_q, fault_q, step_q;
  logic            step_rise, launch, wd_expired;

  tap_edge_sync #(.W(5), .STAGES(SYNC_STAGES)) u_tap_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (tap),
    .rise_o  (tap_rise),
    .fall_o  (tap_fall)
  );

  // A step edge only counts when nothing is in flight (tpclk cycle is still busy).
  assign step_rise  = step_req & ~step_q;
  assign launch     = ~fault_q & (run | (step_rise & ~tpclk_q));
  assign wd_expired = (wd_q == WD_W'(TIMEOUT));

  // Cycle sequencer with registered outputs; watchdog restarts on every state entry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= TAP_100;
      wd_q    <= '0;
      td_in_q <= 1'b0;
      tptse_q <= 1'b0;
      tpclk_q <= 1'b0;
      tpwp_q  <= 1'b0;
      fault_q <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      step_q  <= step_req;
      tpclk_q <= 1'b0;
      tpwp_q  <= 1'b0;
      wd_q    <= wd_q + WD_W'(1);
      case (state_q)
        IDLE: begin
          if (launch) begin
            state_q <= LAUNCH;
            sel_q   <= speed_to_tap(speed, ilong);
            td_in_q <= 1'b1;
            tptse_q <= 1'b1;
            wd_q    <= '0;
          end
        end
        LAUNCH: begin
          state_q <= WAIT_RISE;
          wd_q    <= '0;
        end
        WAIT_RISE: begin
          if (tap_rise[TAP_50]) tpwp_q <= 1'b1;
          if (tap_rise[sel_q]) begin
            state_q <= WAIT_FALL;
            td_in_q <= 1'b0;
            tptse_q <= 1'b0;
            wd_q    <= '0;
          end else if (wd_expired) begin
            state_q <= IDLE;
            td_in_q <= 1'b0;
            tptse_q <= 1'b0;
            fault_q <= 1'b1;
            wd_q    <= '0;
          end
        end
        WAIT_FALL: begin
          if (tap_fall[sel_q]) begin
            state_q <= IDLE;
            tpclk_q <= 1'b1;
            wd_q    <= '0;
          end else if (wd_expired) begin
            state_q <= IDLE;
            td_in_q <= 1'b0;
            tptse_q <= 1'b0;
            fault_q <= 1'b1;
            wd_q    <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign td_in = td_in_q;
  assign tptse = tptse_q;
  assign tpclk = tpclk_q;
  assign tpwp  = tpwp_q;
  assign fault = fault_q;
  // The tpclk clock still counts as busy so a step edge there is not accepted.
  assign busy  = (state_q != IDLE) | tpclk_q;

`ifdef CYCLE_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Count completed cycles; aborts never produce tpclk so they are not counted.
  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else if (tpclk_q) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign cyc_count = cnt_q;
`endif

endmodule

// File: tb/tb_cadr_cycle_timer.sv
// Self-checking bench for cadr_cycle_timer with a 5-tap delay-line model in
// the loop; a scoreboard of expected cycles is drained by a tpclk monitor.
// Build with CYCLE_COUNT_EN defined to also check cyc_count (CNT_W=4).
module tb_cadr_cycle_timer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] tap;
  logic [1:0] speed = 2'd0;
  logic       ilong = 1'b0;
  logic       run = 1'b0;
  logic       step_req = 1'b0;
  logic       td_in, tpclk, tpwp, tptse, busy, fault;
`ifdef CYCLE_COUNT_EN
  localparam int CNT_W = 4;
  logic [CNT_W-1:0] cyc_count;
`endif

  cadr_cycle_timer #(
    .SYNC_STAGES (2),
    .TIMEOUT     (64)
`ifdef CYCLE_COUNT_EN
    , .CNT_W     (CNT_W)
`endif
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .tap      (tap),
    .speed    (speed),
    .ilong    (ilong),
    .run      (run),
    .step_req (step_req),
    .td_in    (td_in),
    .tpclk    (tpclk),
    .tpwp     (tpwp),
    .tptse    (tptse),
    .busy     (busy),
    .fault    (fault)
`ifdef CYCLE_COUNT_EN
    , .cyc_count (cyc_count)
`endif
  );

  always #5 clk = ~clk;

  // Delay line: 10 ns per history slot, tap[i] delayed by (i+1)*50 ns.
  logic [25:0] hist = '0;
  logic        stuck = 1'b0;
  always @(negedge clk) hist <= {hist[24:0], td_in};
  assign tap = stuck ? 5'b0 : {hist[25], hist[20], hist[15], hist[10], hist[5]};

  typedef struct { int sel; bit chk_period; } exp_t;
  exp_t sb_q[$];

  int vectors = 0, miscompares = 0;
  int cyc = 0, td_rise_cyc = 0, td_rises = 0, fault_cyc = 0;
  int tse_cnt = 0, wp_cnt = 0, wp_off = -1, last_tpclk_cyc = 0, tpclk_seen = 0;
  int exp_count = 0;
  bit td_prev = 1'b0, fault_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: timestamps DUT activity and scores each completed cycle.
  initial begin
    exp_t e;
    int   d;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (td_in && !td_prev) begin
        td_rise_cyc = cyc;
        td_rises++;
        tse_cnt = 0;
        wp_cnt  = 0;
        wp_off  = -1;
      end
      if (tptse) tse_cnt++;
      if (tpwp) begin
        wp_cnt++;
        if (wp_off < 0) wp_off = cyc - td_rise_cyc;
      end
      if (fault && !fault_prev) fault_cyc = cyc;
      if (tpclk) begin
        tpclk_seen++;
        if (sb_q.size() == 0) begin
          chk("unexpected_tpclk", 1, 0);
        end else begin
          e = sb_q.pop_front();
          d = 5 * (e.sel + 1);  // delay-line clocks to the terminating tap
          chk_rng("tpclk_offset", cyc - td_rise_cyc, 2*d + 5, 2*d + 7);
          chk_rng("tptse_len", tse_cnt, d + 2, d + 4);
          chk("tpwp_count", wp_cnt, 1);
          chk_rng("tpwp_offset", wp_off, 7, 9);
          if (e.chk_period) chk_rng("tpclk_period", cyc - last_tpclk_cyc, 2*d + 6, 2*d + 8);
        end
        last_tpclk_cyc = cyc;
      end
      td_prev    = td_in;
      fault_prev = fault;
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_td_in"}, int'(td_in), 0);
`ifdef CYCLE_COUNT_EN
    chk({tag, "_cyc_count"}, int'(cyc_count), exp_count % (1 << CNT_W));
`endif
  endtask

  // Wait for the scoreboard to empty, then stop free-running before the next launch.
  task automatic drain(input int budget, input string tag);
    int t = 0;
    while (sb_q.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (sb_q.size() != 0) begin
      chk({tag, "_drain_timeout"}, sb_q.size(), 0);
      sb_q.delete();
    end
    run = 1'b0;
    repeat (4) @(negedge clk);
    check_idle(tag);
  endtask

  task automatic run_seg(input int n, input logic [1:0] sp, input logic il, input bit perturb);
    int s;
    s = il ? 4 : int'(sp) + 1;
    speed = sp;
    ilong = il;
    for (int i = 0; i < n; i++) sb_q.push_back('{sel: s, chk_period: (i > 0)});
    exp_count += n;
    run = 1'b1;
    if (perturb) begin
      repeat (3) @(negedge clk);
      run   = 1'b0;
      speed = 2'($urandom);
      ilong = 1'($urandom);
    end
    drain(200 * n, "seg");
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t, r0, c0;
    repeat (3) @(negedge clk);
    chk("rst_td_in", int'(td_in), 0);
    chk("rst_tpclk", int'(tpclk), 0);
    chk("rst_tpwp", int'(tpwp), 0);
    chk("rst_tptse", int'(tptse), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fault", int'(fault), 0);
`ifdef CYCLE_COUNT_EN
    chk("rst_cyc_count", int'(cyc_count), 0);
`endif
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_seg(17, 2'd0, 1'b0, 1'b0);
    run_seg(3, 2'd3, 1'b0, 1'b0);
    run_seg(3, 2'd0, 1'b1, 1'b0);
    run_seg(2, 2'd1, 1'b0, 1'b0);
    run_seg(1, 2'd2, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      int n;
      n = $urandom_range(1, 3);
      run_seg(n, 2'($urandom), ($urandom_range(0, 3) == 0), (n == 1) && ($urandom_range(0, 1) == 1));
    end

    // Single step: second edge 5 clks later lands while busy and must be dropped.
    speed = 2'd0;
    ilong = 1'b0;
    c0 = tpclk_seen;
    sb_q.push_back('{sel: 1, chk_period: 1'b0});
    exp_count++;
    step_req = 1'b1;
    repeat (2) @(negedge clk);
    step_req = 1'b0;
    repeat (3) @(negedge clk);
    step_req = 1'b1;
    chk("step_busy", int'(busy), 1);
    repeat (150) @(negedge clk);
    step_req = 1'b0;
    chk("step_tpclk_count", tpclk_seen - c0, 1);
    drain(10, "step");

    // Stuck taps: watchdog abort, no tpclk, no relaunch until reset.
    stuck = 1'b1;
    run = 1'b1;
    t = 0;
    while (!fault && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("fault_set", int'(fault), 1);
    chk_rng("fault_latency", fault_cyc - td_rise_cyc, 64, 66);
    chk("fault_td_in", int'(td_in), 0);
    chk("fault_tptse", int'(tptse), 0);
    r0 = td_rises;
    repeat (100) @(negedge clk);
    chk("fault_no_relaunch", td_rises - r0, 0);
    chk("fault_sticky", int'(fault), 1);
    run = 1'b0;
    stuck = 1'b0;
    repeat (30) @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    exp_count = 0;
    @(negedge clk);
    chk("fault_cleared", int'(fault), 0);
    run_seg(1, 2'd0, 1'b0, 1'b0);

    // Reset in WAIT_RISE: outputs clear on that edge, then a fresh cycle follows.
    speed = 2'd0;
    ilong = 1'b0;
    run = 1'b1;
    t = 0;
    while (!td_in && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("rstmid_launched", int'(td_in), 1);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rstmid_td_in", int'(td_in), 0);
    chk("rstmid_tptse", int'(tptse), 0);
    chk("rstmid_busy", int'(busy), 0);
    exp_count = 0;
`ifdef CYCLE_COUNT_EN
    chk("rstmid_cyc_count", int'(cyc_count), 0);
`endif
    repeat (40) @(negedge clk);
    sb_q.push_back('{sel: 1, chk_period: 1'b0});
    exp_count = 1;
    reset_n = 1'b1;
    drain(200, "rstmid");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
